// File: rtl/ne16_tcdm_dyn_mux.sv
// NE16 TCDM dynamic mux: N requesters onto one TCDM master port.
// Round-robin or fixed-priority arbitration, in-order read responses.
module ne16_tcdm_dyn_mux #(
  parameter int NB_CHAN         = 4,
  parameter int DW              = 288,
  parameter int AW              = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          enable_i,
  input  logic                          prio_mode_i,
  input  logic [NB_CHAN-1:0]            in_req_i,
  input  logic [NB_CHAN-1:0]            in_wen_i,
  input  logic [NB_CHAN-1:0][AW-1:0]    in_add_i,
  input  logic [NB_CHAN-1:0][DW/8-1:0]  in_be_i,
  input  logic [NB_CHAN-1:0][DW-1:0]    in_data_i,
  output logic [NB_CHAN-1:0]            in_gnt_o,
  output logic [NB_CHAN-1:0]            in_r_valid_o,
  output logic [DW-1:0]                 in_r_data_o,
  output logic                          out_req_o,
  output logic                          out_wen_o,
  output logic [AW-1:0]                 out_add_o,
  output logic [DW/8-1:0]               out_be_o,
  output logic [DW-1:0]                 out_data_o,
  input  logic                          out_gnt_i,
  input  logic                          out_r_valid_i,
  input  logic [DW-1:0]                 out_r_data_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                          idle_o,
  output logic                          err_o
);

  localparam int CW = $clog2(NB_CHAN);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(MAX_OUTSTANDING);

  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] sel_q, sel_d;
  logic          lock_q, lock_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [MAX_OUTSTANDING-1:0][CW-1:0] id_q, id_d;

  logic [NB_CHAN-1:0] elig;
  logic [CW-1:0]      sel;
  logic [CW-1:0]      idx;
  int                 rr_tmp;
  logic               found, full, empty, hs, push, pop;

  // A stalled request keeps its slot until it is granted or withdrawn.
  always_comb begin
    full  = (cnt_q == CNT_MAX);
    empty = (cnt_q == '0);
    elig  = in_req_i & ~(in_wen_i & {NB_CHAN{full}});
    if (!enable_i || clear_i) elig = '0;
    found  = 1'b0;
    sel    = '0;
    idx    = '0;
    rr_tmp = 0;
    if (lock_q && elig[sel_q]) begin
      found = 1'b1;
      sel   = sel_q;
    end else if (prio_mode_i) begin
      for (int i = 0; i < NB_CHAN; i++) begin
        idx = CW'(i);
        if (!found && elig[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end else begin
      for (int i = 0; i < NB_CHAN; i++) begin
        rr_tmp = int'(rr_ptr_q) + i;
        if (rr_tmp >= NB_CHAN) rr_tmp = rr_tmp - NB_CHAN;
        idx = CW'(rr_tmp);
        if (!found && elig[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end
  end

  always_comb begin
    hs   = found & out_gnt_i;
    push = hs & in_wen_i[sel];
    pop  = out_r_valid_i & ~empty;

    out_req_o  = found;
    out_wen_o  = found ? in_wen_i[sel]  : 1'b0;
    out_add_o  = found ? in_add_i[sel]  : '0;
    out_be_o   = found ? in_be_i[sel]   : '0;
    out_data_o = found ? in_data_i[sel] : '0;

    in_gnt_o      = '0;
    in_gnt_o[sel] = hs;
    in_r_valid_o  = '0;
    in_r_valid_o[id_q[rd_ptr_q]] = pop;
    in_r_data_o   = out_r_data_i;

    outstanding_o = cnt_q;
    idle_o        = ~|in_req_i & empty;
    err_o         = err_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel;
    lock_d   = found & ~out_gnt_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    err_d    = err_q | (out_r_valid_i & empty);
    id_d     = id_q;
    if (hs && !prio_mode_i)
      rr_ptr_d = (sel == CW'(NB_CHAN-1)) ? '0 : sel + 1'b1;
    if (push) begin
      id_d[wr_ptr_q] = sel;
      wr_ptr_d       = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (clear_i) begin
      rr_ptr_d = '0;
      sel_d    = '0;
      lock_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      id_q     <= id_d;
    end
  end

endmodule

// File: tb/tb_ne16_tcdm_dyn_mux.sv
// Bench for ne16_tcdm_dyn_mux: directed scenarios plus random traffic,
// arbitration reference model and in-order response scoreboard.
module tb_ne16_tcdm_dyn_mux;

  localparam int N  = 4;
  localparam int DW = 288;
  localparam int AW = 32;
  localparam int BW = DW/8;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_ni, clear_i, enable_i, prio_mode_i;
  logic [N-1:0]         in_req_i, in_wen_i;
  logic [N-1:0][AW-1:0] in_add_i;
  logic [N-1:0][BW-1:0] in_be_i;
  logic [N-1:0][DW-1:0] in_data_i;
  logic [N-1:0]         in_gnt_o, in_r_valid_o;
  logic [DW-1:0]        in_r_data_o;
  logic                 out_req_o, out_wen_o;
  logic [AW-1:0]        out_add_o;
  logic [BW-1:0]        out_be_o;
  logic [DW-1:0]        out_data_o;
  logic                 out_gnt_i, out_r_valid_i;
  logic [DW-1:0]        out_r_data_i;
  logic [2:0]           outstanding_o;
  logic                 idle_o, err_o;

  ne16_tcdm_dyn_mux #(.NB_CHAN(N), .DW(DW), .AW(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .prio_mode_i(prio_mode_i), .in_req_i(in_req_i), .in_wen_i(in_wen_i),
    .in_add_i(in_add_i), .in_be_i(in_be_i), .in_data_i(in_data_i),
    .in_gnt_o(in_gnt_o), .in_r_valid_o(in_r_valid_o), .in_r_data_o(in_r_data_o),
    .out_req_o(out_req_o), .out_wen_o(out_wen_o), .out_add_o(out_add_o),
    .out_be_o(out_be_o), .out_data_o(out_data_o), .out_gnt_i(out_gnt_i),
    .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
    .outstanding_o(outstanding_o), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [AW-1:0] add; } exp_t;
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  exp_t exp_q[$];
  rsp_t slv_q[$];

  int ncmp = 0, nerr = 0;
  int cyc = 0, last_due = 0, peak = 0;
  int m_rr = 0, m_cnt = 0, held = -1;
  bit m_err = 0;
  int gcnt[N];

  logic [N-1:0]         s_req = '0, s_wen = '0;
  logic [N-1:0][AW-1:0] s_add = '0;
  logic [N-1:0][BW-1:0] s_be = '0;
  logic [N-1:0][DW-1:0] s_data = '0;
  bit s_gnt = 1, s_en = 1, s_prio = 0, s_clr = 0, hold_rsp = 0, spur = 0;
  int lat_lo = 1, lat_hi = 1;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = a ^ (32'h9E37_79B9 * (i + 1));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_cnt = 0; held = -1; m_err = 0;
    exp_q.delete(); slv_q.delete(); last_due = 0;
  endtask

  task automatic randomize_fields();
    for (int k = 0; k < N; k++) begin
      s_add[k] = $urandom;
      s_be[k]  = {4'($urandom), 32'($urandom)};
      for (int w = 0; w < DW/32; w++) s_data[k][w*32 +: 32] = $urandom;
    end
  endtask

  task automatic step();
    bit rv, full;
    int sel, cnt0, due, lat;
    logic [N-1:0] el;
    @(posedge clk); #1;
    cyc++;
    rv = 0;
    out_r_data_i = '0;
    if (spur) begin
      rv = 1; out_r_data_i = {9{32'hDEAD_BEEF}};
    end else if (!hold_rsp && !s_clr && slv_q.size() > 0 && slv_q[0].due <= cyc) begin
      rv = 1; out_r_data_i = slv_q[0].data; void'(slv_q.pop_front());
    end
    out_r_valid_i = rv;
    in_req_i = s_req; in_wen_i = s_wen; in_add_i = s_add;
    in_be_i = s_be; in_data_i = s_data; out_gnt_i = s_gnt;
    enable_i = s_en; prio_mode_i = s_prio; clear_i = s_clr;
    @(negedge clk);
    if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
    chk("outstanding", outstanding_o, m_cnt);
    chk("err", err_o, m_err);
    chk("idle", idle_o, (s_req == 0 && m_cnt == 0));
    cnt0 = m_cnt;
    full = (m_cnt >= MO);
    el = s_req & ~(s_wen & {N{full}});
    if (!s_en || s_clr) el = '0;
    sel = -1;
    if (held >= 0 && el[held]) sel = held;
    else
      for (int i = 0; i < N; i++) begin
        int k;
        k = s_prio ? i : (m_rr + i) % N;
        if (sel < 0 && el[k]) sel = k;
      end
    chk("out_req", out_req_o, sel >= 0);
    chk("in_gnt", in_gnt_o, (s_gnt && sel >= 0) ? (1 << sel) : 0);
    chk("r_valid_any", |in_r_valid_o, rv && cnt0 > 0);
    if (sel >= 0 && s_gnt) begin
      chk("out_add", out_add_o, s_add[sel]);
      chk("out_wen", out_wen_o, s_wen[sel]);
      chk("out_be", out_be_o, s_be[sel]);
      if (!s_wen[sel]) chk("out_data", out_data_o, s_data[sel]);
      gcnt[sel]++;
      if (!s_prio) m_rr = (sel + 1) % N;
      if (s_wen[sel]) begin
        exp_q.push_back('{sel, s_add[sel]});
        lat = $urandom_range(lat_hi, lat_lo);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        slv_q.push_back('{due, data_of(out_add_o)});
        m_cnt++;
      end
    end
    held = (sel >= 0 && !s_gnt) ? sel : -1;
    if (rv && cnt0 > 0) m_cnt--;
    if (rv && cnt0 == 0) m_err = 1;
    if (s_clr) model_reset();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    s_req = '0; in_req_i = '0; out_r_valid_i = 1'b0; clear_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_err", err_o, 0);
    chk("rst_out_req", out_req_o, 0);
    chk("rst_gnt", in_gnt_o, 0);
    chk("rst_r_valid", in_r_valid_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    s_req = '0; hold_rsp = 0; spur = 0; s_clr = 0;
    for (int i = 0; i < 40 && slv_q.size() > 0; i++) step();
    step();
    chk("drain_slave", slv_q.size(), 0);
    chk("drain_scoreboard", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_ni && |in_r_valid_o) begin
      if (exp_q.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL r_valid_unexpected @cyc %0d: got %0h expected none", cyc, in_r_valid_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("r_valid_ch", in_r_valid_o, 1 << e.ch);
        chk("r_data", in_r_data_o, data_of(e.add));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; clear_i = 0; enable_i = 1; prio_mode_i = 0;
    in_req_i = '0; in_wen_i = '0; in_add_i = '0; in_be_i = '0; in_data_i = '0;
    out_gnt_i = 0; out_r_valid_i = 0; out_r_data_i = '0;
    for (int k = 0; k < N; k++) gcnt[k] = 0;
    do_reset();

    // round-robin reads, fixed 2-cycle latency
    randomize_fields();
    s_req = 4'hF; s_wen = 4'hF; s_gnt = 1; lat_lo = 2; lat_hi = 2; peak = 0;
    for (int i = 0; i < 12; i++) step();
    chk("rr_peak_outstanding", peak, 2);
    drain();

    // fixed priority: ch1 starves ch3
    s_prio = 1; s_req = 4'b1010; s_wen = 4'b0000;
    for (int i = 0; i < 6; i++) step();
    s_req = 4'b1000;
    for (int i = 0; i < 2; i++) step();
    s_prio = 0;

    // fill the ID FIFO with ch0 reads, writes still pass
    for (int k = 0; k < N; k++) gcnt[k] = 0;
    hold_rsp = 1; s_req = 4'b0001; s_wen = 4'b0001;
    for (int i = 0; i < 6; i++) step();
    chk("ch0_grants_full", gcnt[0], 4);
    s_req = 4'b0101;
    for (int i = 0; i < 2; i++) step();
    chk("ch2_write_grants", gcnt[2], 2);
    // one response frees a slot, ch0 regranted next cycle
    s_req = 4'b0001;
    hold_rsp = 0; step();
    hold_rsp = 1; step();
    step();
    chk("ch0_grants_refill", gcnt[0], 5);
    drain();

    // spurious response sets sticky error, clear restores rr pointer
    s_req = 4'b0010; s_wen = 4'b0000; step();
    s_req = '0; spur = 1; step();
    spur = 0;
    for (int i = 0; i < 3; i++) step();
    s_clr = 1; step();
    s_clr = 0; s_req = 4'hF; step();
    s_req = '0; step();

    // reset with reads in flight, late response flagged
    hold_rsp = 1; s_req = 4'b0001; s_wen = 4'b0001;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    hold_rsp = 0; spur = 1; step();
    spur = 0; step();
    s_clr = 1; step();
    s_clr = 0;

    // random traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      randomize_fields();
      s_req = 4'($urandom); s_wen = 4'($urandom);
      s_gnt = $urandom_range(0, 3) != 0;
      s_en = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 7) == 0) s_prio = ~s_prio;
      s_clr = $urandom_range(0, 299) == 0;
      hold_rsp = $urandom_range(0, 3) == 0;
      step();
    end
    s_en = 1; s_clr = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ne16_tcdm_dyn_mux.md
NE16_TCDM_DYN_MUX -- requirements
Module: ne16_tcdm_dyn_mux

Interface
REQ-001 Parameter NB_CHAN, default 4, number of requesting channels (2..8).
REQ-002 Parameter DW, default 288, data width in bits; byte enable width is DW/8.
REQ-003 Parameter AW, default 32, address width.
REQ-004 Parameter MAX_OUTSTANDING, default 4, ID FIFO depth (power of 2, >=2).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 clear_i  in  1  synchronous soft clear.
REQ-008 enable_i  in  1  when 0, no new request is forwarded; responses still drain.
REQ-009 prio_mode_i  in  1  arbitration: 0 = round-robin, 1 = fixed priority, lowest index wins.
REQ-010 in_req_i/in_wen_i  in  NB_CHAN  per-channel request and write-enable (1 = read, 0 = write).
REQ-011 in_add_i/in_be_i/in_data_i  in  NB_CHAN x AW/DW/8/DW  per-channel address, byte enable, write data.
REQ-012 in_gnt_o/in_r_valid_o  out  NB_CHAN  per-channel grant and read-response valid.
REQ-013 in_r_data_o  out  DW  read data, broadcast to all channels.
REQ-014 out_req_o/out_wen_o/out_add_o/out_be_o/out_data_o  out  1/1/AW/DW/8/DW  master-side request.
REQ-015 out_gnt_i/out_r_valid_i/out_r_data_i  in  1/1/DW  master-side grant, response valid, data.
REQ-016 outstanding_o  out  clog2(MAX_OUTSTANDING)+1  reads in flight; idle_o  out  1  no request pending and outstanding_o==0; err_o  out  1  sticky protocol error.

Function
REQ-017 Eligible set = channels with in_req_i=1, minus read channels when ID FIFO full; empty set or enable_i=0 -> out_req_o=0.
REQ-018 Exactly one eligible channel is selected combinationally per cycle; out_* fields are that channel's, unregistered (zero added latency).
REQ-019 in_gnt_o[k] = out_gnt_i & out_req_o & (selected==k); all other grants 0.
REQ-020 Round-robin: search starts at rr_ptr; on each handshake (out_req_o & out_gnt_i) rr_ptr <= selected+1 modulo NB_CHAN; no handshake -> rr_ptr unchanged.
REQ-021 Fixed priority: lowest-index eligible channel selected; rr_ptr not updated.
REQ-022 prio_mode_i sampled every cycle; switching mid-stream requires no idle gap.
REQ-023 Selection holds while out_req_o=1 and out_gnt_i=0 unless the selected channel drops in_req_i.
REQ-024 Read handshake pushes selected channel ID into ID FIFO; write handshake pushes nothing.
REQ-025 out_r_valid_i pops FIFO head; in_r_valid_o[head]=1 same cycle; in_r_data_o=out_r_data_i combinationally.
REQ-026 Responses in order, any latency >=1 cycle after grant.
REQ-027 Push and pop same cycle: count unchanged, both pointers advance; allowed when full (push eligible only if pop in same cycle is not relied on: full blocks reads, REQ-017).
REQ-028 out_r_valid_i with FIFO empty: dropped, no in_r_valid_o, err_o set to 1 and held until reset or clear_i.
REQ-029 Pointers wrap modulo MAX_OUTSTANDING; count saturates neither way (full blocks push, empty blocks pop).
REQ-030 Writes not blocked by full FIFO and may overtake pending reads.

Reset
REQ-031 rst_ni=0: rr_ptr=0, FIFO pointers and count=0, err_o=0; all outputs 0, idle_o=1 (with in_req_i=0).
REQ-032 clear_i=1: same state reset on next edge; responses arriving after clear for pre-clear reads are dropped and set err_o; no grant issued in clear cycle.
REQ-033 Reset mid-transaction discards in-flight IDs; no r_valid is forwarded for them.

Verification
REQ-034 NB_CHAN=4, rr mode, all in_req_i=1 reads, out_gnt_i=1, r_valid 2 cycles later -> grants 0,1,2,3,0...; r_valid order matches; outstanding_o peaks 2.
REQ-035 Fixed mode, ch1 and ch3 requesting -> ch1 granted every cycle, ch3 starved until ch1 drops.
REQ-036 Hold r_valid low, ch0 reads continuously -> 4 grants, then out_req_o=0 for ch0; ch2 write still granted; outstanding_o=4.
REQ-037 FIFO full, one r_valid and ch0 read pending -> pop this cycle, ch0 regranted next cycle; count 4->3->4.
REQ-038 out_r_valid_i pulse with empty FIFO -> no in_r_valid_o, err_o=1 until clear_i; clear_i -> err_o=0, rr_ptr=0.
REQ-039 Assert rst_ni=0 with 3 reads outstanding -> outstanding_o=0 immediately, idle_o=1, late r_valid sets err_o.
